// File: rtl/regfile_32x32_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_32x32_2r1w
//   32-entry register storage with one synchronous write port and two
//   combinational read ports.
//
//   Ports
//     clk     in   1       clock; all state changes on the rising edge
//     reset   in   1       asynchronous, active-high; clears every register
//     we      in   1       write enable, sampled on the rising clk edge
//     waddr   in   5       write register index
//     wdata   in   DATA_W  write data
//     raddr1  in   5       read port 1 index
//     raddr2  in   5       read port 2 index
//     rdata1  out  DATA_W  read port 1 data (combinational)
//     rdata2  out  DATA_W  read port 2 data (combinational)
//
//   Parameters
//     DATA_W   width of each register word
//     ZERO_R0  1: register 0 reads as zero and ignores writes
//
//   Build option
//     REGFILE_WRITE_BYPASS_EN  when defined, a read of the index being written
//                              in the current cycle returns wdata directly.
//                              Undefined (default): reads return stored
//                              contents only.
// -----------------------------------------------------------------------------
module regfile_32x32_2r1w #(
  parameter int DATA_W  = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [32];
  logic [31:0]       wsel_d;

  // One-hot write decode; the r0 lane is suppressed when r0 is hardwired.
  always_comb begin
    wsel_d        = '0;
    wsel_d[waddr] = we;
    if (ZERO_R0) wsel_d[0] = 1'b0;
  end

  for (genvar g = 0; g < 32; g++) begin : g_reg
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs_q[g] <= '0;
      end else if (wsel_d[g]) begin
        regs_q[g] <= wdata;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_q[addr];
    if (ZERO_R0 && (addr == 5'd0)) val = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight write; never forwards into a hardwired r0.
    if (we && (addr == waddr) && !(ZERO_R0 && (addr == 5'd0))) val = wdata;
`endif
    // Storage is already clear during reset; the explicit gate also keeps
    // the forwarding path from leaking wdata while reset is held.
    if (reset) val = '0;
    return val;
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);

endmodule

// File: tb/tb_regfile_32x32_2r1w.sv
module tb_regfile_32x32_2r1w;

  localparam int DATA_W  = 32;
  localparam bit ZERO_R0 = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              we;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [4:0]        raddr1;
  logic [4:0]        raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference contents of the register file as the specification describes it.
  logic [DATA_W-1:0] model [32];

  typedef struct {
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [DATA_W-1:0] exp1;
    logic [DATA_W-1:0] exp2;
  } vec_t;
  vec_t vecs [34];

  regfile_32x32_2r1w #(.DATA_W(DATA_W), .ZERO_R0(ZERO_R0)) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endfunction

  // Value a read port should show right now, given the pending write inputs.
  function automatic logic [DATA_W-1:0] expect_read(input logic [4:0] a);
    if (reset) return '0;
    if (ZERO_R0 && a == 5'd0) return '0;
    if (BYPASS && we && a == waddr) return wdata;
    return model[a];
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    if (!(ZERO_R0 && a == 5'd0)) model[a] = d;
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    model_clear();

    // Reset state: every index reads zero while reset is held.
    #2;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
      check("reset_rd1", rdata1, '0);
      check("reset_rd2", rdata2, '0);
    end
    tick(); tick();
    reset = 1'b0;

    // 1. Mid-cycle asynchronous reset clears a freshly written register.
    do_write(5'd5, 32'hAEAEAE05);
    raddr1 = 5'd5; #1;
    check("t1_pre_reset", rdata1, 32'hAEAEAE05);
    #3 reset = 1'b1; #1;
    check("t1_async_clear", rdata1, '0);
    model_clear();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); #0.1;
      check("t1_all_zero", rdata1, '0);
    end
    tick();
    reset = 1'b0;

    // 2. Fill every register, then sweep both ports from the table.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hAEAEAE00 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      vecs[i].ra1  = 5'(i);
      vecs[i].ra2  = 5'(31 - i);
      vecs[i].exp1 = (ZERO_R0 && i == 0) ? '0 : 32'hAEAEAE00 + 32'(i);
      vecs[i].exp2 = (ZERO_R0 && i == 31) ? '0 : 32'hAEAEAE00 + 32'(31 - i);
    end
    vecs[32] = '{5'd30, 5'd31, 32'hAEAEAE1E, 32'hAEAEAE1F};
    vecs[33] = '{5'd31, 5'd30, 32'hAEAEAE1F, 32'hAEAEAE1E};
    for (int i = 0; i < 34; i++) begin
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2; #1;
      check($sformatf("t2_rd1[%0d]", vecs[i].ra1), rdata1, vecs[i].exp1);
      check($sformatf("t2_rd2[%0d]", vecs[i].ra2), rdata2, vecs[i].exp2);
    end

    // 3. Read of the index being written in the same cycle.
    we = 1'b1; waddr = 5'd6; wdata = 32'hDEADBEEF; raddr1 = 5'd6; #1;
    check("t3_same_cycle", rdata1, BYPASS ? 32'hDEADBEEF : 32'hAEAEAE06);
    tick();
    model[6] = 32'hDEADBEEF;
    we = 1'b0; #1;
    check("t3_after_edge", rdata1, 32'hDEADBEEF);

    // 4. we=0 must not disturb the addressed register.
    we = 1'b0; waddr = 5'd28; wdata = 32'h12345678;
    tick(); tick(); tick();
    raddr1 = 5'd28; #1;
    check("t4_no_write", rdata1, 32'hAEAEAE1C);

    // 5. Both ports on one index, then split.
    raddr1 = 5'b11100; raddr2 = 5'b11100; #1;
    check("t5_same_rd1", rdata1, 32'hAEAEAE1C);
    check("t5_same_rd2", rdata2, 32'hAEAEAE1C);
    raddr2 = 5'b11110; #1;
    check("t5_split_rd2", rdata2, 32'hAEAEAE1E);
    check("t5_split_rd1", rdata1, 32'hAEAEAE1C);

    // 6. Write attempted across an edge while reset is held.
    reset = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; raddr1 = 5'd3;
    model_clear();
    #1;
    check("t6_rd_in_reset", rdata1, '0);
    tick();
    reset = 1'b0; we = 1'b0; #1;
    check("t6_blocked", rdata1, '0);
    do_write(5'd3, 32'h0000C0DE);
    #1;
    check("t6_first_write", rdata1, 32'h0000C0DE);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      check("rand_rd1", rdata1, expect_read(raddr1));
      check("rand_rd2", rdata2, expect_read(raddr2));
      tick();
      if (we && !(ZERO_R0 && waddr == 5'd0)) model[waddr] = wdata;
    end
    we = 1'b0; #1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); #1;
      check("final_sweep", rdata1, expect_read(5'(i)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
